// File: rtl/array_mul_pkg.sv
// Shared constants and types for the array_mul block: default Q10.16 format,
// FSM state encoding and the signed saturation limits for the default width.
package array_mul_pkg;

    localparam int W_DEF    = 27;
    localparam int FRAC_DEF = 16;
    localparam int N_DEF    = 6;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } state_t;

    localparam logic signed [W_DEF-1:0] SAT_MAX = {1'b0, {(W_DEF-1){1'b1}}};
    localparam logic signed [W_DEF-1:0] SAT_MIN = {1'b1, {(W_DEF-1){1'b0}}};

endpackage

// File: rtl/mul_q16.sv
// One-stage registered signed W x W multiplier with fixed-point rescale.
// Saturation to the signed W-bit range is compiled in with ARRAY_MUL_SAT_EN.
module mul_q16
    import array_mul_pkg::*;
#(
    parameter int W    = W_DEF,
    parameter int FRAC = FRAC_DEF
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                clken,
    input  logic                in_valid,
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    output logic                out_valid,
    output logic signed [W-1:0] result
`ifdef ARRAY_MUL_SAT_EN
    ,
    output logic                ovf
`endif
);

    localparam int PW = 2 * W;

    logic signed [PW-1:0] prod_q;
    logic signed [W-1:0]  scaled;

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prod_q    <= '0;
            out_valid <= 1'b0;
        end else if (clken) begin
            prod_q    <= PW'(a) * PW'(b);
            out_valid <= in_valid;
        end
    end

    // Arithmetic shift right by FRAC: floor rounding comes from dropping low bits.
    assign scaled = prod_q[W+FRAC-1:FRAC];

`ifdef ARRAY_MUL_SAT_EN
    localparam int                HW     = PW - (W + FRAC - 1);
    localparam logic signed [W-1:0] LIM_HI = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0] LIM_LO = {1'b1, {(W-1){1'b0}}};

    logic [HW-1:0] head;
    logic          unused_bits;

    // In range only when every bit above the result's sign bit matches it.
    assign head        = prod_q[PW-1:W+FRAC-1];
    assign unused_bits = ^prod_q[FRAC-1:0];

    always_comb begin
        result = scaled;
        ovf    = 1'b0;
        if (!((head == '0) || (head == '1))) begin
            ovf    = 1'b1;
            result = prod_q[PW-1] ? LIM_LO : LIM_HI;
        end
    end
`else
    logic unused_bits;

    assign unused_bits = ^{prod_q[PW-1:W+FRAC], prod_q[FRAC-1:0]};
    assign result      = scaled;
`endif

endmodule

// File: rtl/array_mul.sv
// Scales an N-element signed fixed-point array by a common factor through one
// shared pipelined multiplier. ARRAY_MUL_SAT_EN enables saturation and ovf.
module array_mul
    import array_mul_pkg::*;
#(
    parameter int N    = N_DEF,
    parameter int W    = W_DEF,
    parameter int FRAC = FRAC_DEF
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                en,
    input  logic                start,
    input  logic signed [W-1:0] factor,
    input  logic [N-1:0][W-1:0] operands,
    output logic [N-1:0][W-1:0] products,
    output logic                busy,
    output logic                done,
    output logic                ovf
);

    localparam int            IW   = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    state_t              state;
    state_t              state_nx;
    logic [IW-1:0]       idx;
    logic [IW-1:0]       wr_idx;
    logic signed [W-1:0] fac_q;
    logic [N-1:0][W-1:0] ops_q;
    logic                capture;
    logic                issue;
    logic                mul_valid;
    logic signed [W-1:0] mul_res;

    assign capture = (state == IDLE) && en && start;
    assign issue   = (state == ISSUE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            idx    <= '0;
            wr_idx <= '0;
        end else if (en) begin
            state  <= state_nx;
            wr_idx <= idx;
            if (capture)
                idx <= '0;
            else if (issue && (idx != LAST))
                idx <= idx + IW'(1);
        end
    end

    // NOTE: every output of this block gets a default first so no path
    // through the case leaves a signal unassigned and infers a latch.
    always_comb begin
        state_nx = state;
        busy     = 1'b1;
        done     = 1'b0;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_nx = ISSUE;
            end
            ISSUE: if (idx == LAST) state_nx = DRAIN;
            DRAIN: state_nx = DONE;
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // NOTE: capture registers carry no reset; they are always loaded at start
    // before being read, so resetting them would only add reset fanout.
    always_ff @(posedge clk) begin
        if (capture) begin
            fac_q <= factor;
            ops_q <= operands;
        end
    end

`ifdef ARRAY_MUL_SAT_EN
    logic mul_ovf;
    logic ovf_q;
`endif

    mul_q16 #(
        .W    (W),
        .FRAC (FRAC)
    ) u_mul (
        .clk       (clk),
        .reset_n   (reset_n),
        .clken     (en),
        .in_valid  (issue),
        .a         (ops_q[idx]),
        .b         (fac_q),
        .out_valid (mul_valid),
        .result    (mul_res)
`ifdef ARRAY_MUL_SAT_EN
        ,
        .ovf       (mul_ovf)
`endif
    );

    // Results land one enabled cycle behind issue, tagged by the delayed index.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            products <= '0;
        else if (en && mul_valid)
            products[wr_idx] <= mul_res;
    end

`ifdef ARRAY_MUL_SAT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            ovf_q <= 1'b0;
        else if (capture)
            ovf_q <= 1'b0;
        else if (en && mul_valid && mul_ovf)
            ovf_q <= 1'b1;
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: doc/array_mul.md
ARRAY_MUL -- requirements
Module: array_mul

Interface
- REQ-001 The block SHALL have parameter N, default 6, meaning the number of array elements.
- REQ-002 The block SHALL have parameter W, default 27, meaning the element width as signed fixed point.
- REQ-003 The block SHALL have parameter FRAC, default 16, meaning the fractional bits (Q10.16).
- REQ-004 Port clk, input, 1 bit: the single clock, rising edge.
- REQ-005 Port reset_n, input, 1 bit: reset, asynchronous and active-low.
- REQ-006 Port en, input, 1 bit: clock enable; when low, all state holds.
- REQ-007 Port start, input, 1 bit: request to begin an operation.
- REQ-008 Port factor, input, W bits, signed: the common multiplier.
- REQ-009 Port operands, input, N x W bits, signed: the array to scale.
- REQ-010 Port products, output, N x W bits, signed: the results.
- REQ-011 Port busy, output, 1 bit: an operation is in progress.
- REQ-012 Port done, output, 1 bit: one-cycle completion pulse.
- REQ-013 Port ovf, output, 1 bit: sticky overflow flag for the last operation.

Function
- REQ-014 The block SHALL compute products[k] = (operands[k] * factor) >>> FRAC for every k, using one shared W x W signed multiplier that the FSM time-multiplexes.
- REQ-015 The FSM states SHALL be IDLE, ISSUE, DRAIN and DONE.
- REQ-016 Every transition SHALL require en=1; with en=0 the FSM, counters, pipeline and outputs SHALL hold, and done SHALL not be re-pulsed.
- REQ-017 In IDLE, start=1 at edge T SHALL capture factor and all operands into internal registers, clear ovf, clear the index to 0, and enter ISSUE.
- REQ-018 In ISSUE, one element per enabled cycle SHALL be issued to the multiplier, in index order 0..N-1.
- REQ-019 After index N-1 is issued, the FSM SHALL enter DRAIN.
- REQ-020 The multiplier SHALL have exactly one register stage.
- REQ-021 Each products[k] SHALL be written one enabled cycle after element k is issued.
- REQ-022 DRAIN SHALL last one cycle, during which the last write occurs, and SHALL then enter DONE.
- REQ-023 In DONE, done SHALL be 1 for exactly one cycle, and the FSM SHALL then return to IDLE.
- REQ-024 With en held at 1, done SHALL be high in cycle T+N+2.
- REQ-025 busy SHALL be 1 in ISSUE, DRAIN and DONE, and 0 in IDLE.
- REQ-026 start SHALL be ignored while busy=1.
- REQ-027 Input changes after capture SHALL not affect the operation in flight.
- REQ-028 products SHALL retain their last values until overwritten, element by element, by the next operation.
- REQ-029 The full product SHALL be 2W bits wide.
- REQ-030 The scaled result SHALL be bits [W+FRAC-1:FRAC] of the full product (arithmetic shift, rounding toward negative infinity).
- REQ-031 N=1 SHALL be supported, giving done at T+3.

Reset
- REQ-032 reset_n low SHALL asynchronously force IDLE, index 0, products all 0, busy 0, done 0 and ovf 0, including in the middle of an operation.
- REQ-033 After a reset, no partial result SHALL remain, and a start in the first enabled cycle after release SHALL be accepted.

Configuration
- REQ-034 With ARRAY_MUL_SAT_EN defined, a scaled result outside the signed W-bit range SHALL clamp to 2^(W-1)-1 or -2^(W-1), and ovf SHALL be set and remain set until the next start.
- REQ-035 With ARRAY_MUL_SAT_EN undefined, results SHALL wrap (truncate to W bits), and ovf SHALL be tied to 0.

Structure
- REQ-036 A shared package array_mul_pkg SHALL hold the constants W_DEF=27 and FRAC_DEF=16, the state enum type, and the saturation limit constants.
- REQ-037 A sub-module mul_q16 SHALL contain the registered signed multiply, the shift and the optional saturation, with a clken input driven by en.
- REQ-038 The top level SHALL contain the FSM, the index counter, the capture registers and the result write-back.

Verification
- REQ-039 Scaling case: factor=131072 (2.0), all operands=196608 (3.0), start at T with en=1 -> all products=393216, done high only at T+8 (N=6), busy high T+1..T+8.
- REQ-040 Sign case: operand -98304 (-1.5) x factor 131072 -> product -196608; operand -1 x factor 65536 -> product -1.
- REQ-041 Overflow case: operand 67108863 x factor 131072 -> 67108863 with ovf=1 when ARRAY_MUL_SAT_EN is defined, -2 with ovf=0 when it is undefined.
- REQ-042 Stall case: en=0 for 3 cycles during ISSUE -> results unchanged and done delayed by exactly 3 cycles; a start pulsed while busy -> no effect.
- REQ-043 Reset case: reset_n low at T+3 -> products all 0, busy 0 and done 0 immediately; no done pulse follows; a new start completes normally.
- REQ-044 Input-change case: operands changed at T+1 -> results reflect the values captured at T.
